// File: rtl/shift_request_queue.sv
// rtl/shift_request_queue.sv - FIFO of shift requests feeding the combinational shifter
// Head entry drives the shifter directly and reads as zero (LSL 0 by 0) when empty.
module shift_request_queue #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       wr_valid,
  output logic                       wr_ready,
  input  logic [W-1:0]               wr_data,
  input  logic [4:0]                 wr_shamt,
  input  logic [1:0]                 wr_control,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [W-1:0]               rd_data,
  output logic [4:0]                 rd_shamt,
  output logic [1:0]                 rd_control,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [W-1:0]  data_q  [DEPTH];
  logic [4:0]    shamt_q [DEPTH];
  logic [1:0]    ctl_q   [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;

  logic full, empty, push, pop;

  // Handshake flags come only from registered occupancy, never from wr_valid/rd_ready.
  assign full     = (level_q == LW'(DEPTH));
  assign empty    = (level_q == '0);
  assign wr_ready = !full;
  assign rd_valid = !empty;
  assign push     = wr_valid && wr_ready;
  assign pop      = rd_valid && rd_ready;
  assign level    = level_q;

  assign rd_data    = empty ? '0 : data_q[rd_ptr_q];
  assign rd_shamt   = empty ? '0 : shamt_q[rd_ptr_q];
  assign rd_control = empty ? '0 : ctl_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Storage is deliberately left unreset; empty-forcing hides stale contents.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      data_q[wr_ptr_q]  <= wr_data;
      shamt_q[wr_ptr_q] <= wr_shamt;
      ctl_q[wr_ptr_q]   <= wr_control;
    end
  end

endmodule

// File: tb/tb_shift_request_queue.sv
// tb/tb_shift_request_queue.sv - directed self-checking bench for shift_request_queue
module tb_shift_request_queue;

  logic        clk;
  logic        reset_n;
  logic        flush;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_data;
  logic [4:0]  wr_shamt;
  logic [1:0]  wr_control;
  logic        rd_valid;
  logic        rd_ready;
  logic [31:0] rd_data;
  logic [4:0]  rd_shamt;
  logic [1:0]  rd_control;
  logic [2:0]  level;

  int total = 0;
  int bad   = 0;

  shift_request_queue #(.W(32), .DEPTH(4)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .flush      (flush),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_data    (wr_data),
    .wr_shamt   (wr_shamt),
    .wr_control (wr_control),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .rd_data    (rd_data),
    .rd_shamt   (rd_shamt),
    .rd_control (rd_control),
    .level      (level)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, " level"},    64'(level), 64'd0);
    chk({tag, " rd_valid"}, 64'(rd_valid), 64'd0);
    chk({tag, " rd_data"},  64'(rd_data), 64'd0);
    chk({tag, " rd_shamt"}, 64'(rd_shamt), 64'd0);
    chk({tag, " rd_ctl"},   64'(rd_control), 64'd0);
    chk({tag, " wr_ready"}, 64'(wr_ready), 64'd1);
  endtask

  task automatic push1(input logic [31:0] d);
    wr_valid = 1'b1; wr_data = d; wr_shamt = d[4:0]; wr_control = d[1:0];
    step();
    wr_valid = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0; wr_valid = 1'b0; rd_ready = 1'b0;
    wr_data = '0; wr_shamt = '0; wr_control = '0;
    #2;
    chk_empty("reset");
    step();
    reset_n = 1'b1;

    // Single request, then pop
    wr_valid = 1'b1; wr_data = 32'h8000_0001; wr_shamt = 5'd4; wr_control = 2'b11;
    step();
    wr_valid = 1'b0;
    chk("single rd_valid", 64'(rd_valid), 64'd1);
    chk("single rd_data",  64'(rd_data), 64'h8000_0001);
    chk("single rd_shamt", 64'(rd_shamt), 64'd4);
    chk("single rd_ctl",   64'(rd_control), 64'd3);
    chk("single level",    64'(level), 64'd1);
    rd_ready = 1'b1;
    step();
    rd_ready = 1'b0;
    chk_empty("single pop");

    // Fill to full
    for (int i = 1; i <= 4; i++) push1(32'(i));
    chk("full level", 64'(level), 64'd4);
    chk("full wr_ready", 64'(wr_ready), 64'd0);
    chk("full head", 64'(rd_data), 64'd1);
    wr_valid = 1'b1; wr_data = 32'd5; wr_shamt = 5'd5; wr_control = 2'd1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("held level", 64'(level), 64'd4);
      chk("held head", 64'(rd_data), 64'd1);
    end
    // Full with push+pop: only pop occurs
    rd_ready = 1'b1;
    step();
    chk("fullrw level", 64'(level), 64'd3);
    chk("fullrw head", 64'(rd_data), 64'd2);
    chk("fullrw wr_ready", 64'(wr_ready), 64'd1);
    rd_ready = 1'b0;
    step();
    wr_valid = 1'b0;
    chk("refill level", 64'(level), 64'd4);
    rd_ready = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      chk("drain rd_valid", 64'(rd_valid), 64'd1);
      chk("drain data",     64'(rd_data), 64'(i));
      chk("drain shamt",    64'(rd_shamt), 64'(i));
      chk("drain ctl",      64'(rd_control), 64'(i % 4));
      step();
    end
    rd_ready = 1'b0;
    chk_empty("drained");

    // Simultaneous push and pop at level 2, across pointer wrap
    push1(32'd10);
    push1(32'd11);
    wr_valid = 1'b1; rd_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wr_data = 32'(12 + i); wr_shamt = 5'(12 + i); wr_control = 2'(i);
      chk("stream head", 64'(rd_data), 64'(10 + i));
      step();
      chk("stream level", 64'(level), 64'd2);
    end
    wr_valid = 1'b0;
    chk("stream tail0", 64'(rd_data), 64'd20);
    step();
    chk("stream tail1", 64'(rd_data), 64'd21);
    step();
    rd_ready = 1'b0;
    chk_empty("stream end");

    // Flush beats push and pop
    push1(32'd20); push1(32'd21); push1(32'd22);
    chk("preflush level", 64'(level), 64'd3);
    wr_valid = 1'b1; rd_ready = 1'b1; flush = 1'b1; wr_data = 32'd23;
    step();
    wr_valid = 1'b0; rd_ready = 1'b0; flush = 1'b0;
    chk_empty("flush");

    // Asynchronous reset mid-cycle
    push1(32'd30); push1(32'd31);
    chk("prereset level", 64'(level), 64'd2);
    #3 reset_n = 1'b0;
    #1;
    chk("async level", 64'(level), 64'd0);
    chk("async rd_valid", 64'(rd_valid), 64'd0);
    chk("async rd_data", 64'(rd_data), 64'd0);
    #1 reset_n = 1'b1;
    wr_valid = 1'b1; wr_data = 32'd40; wr_shamt = 5'd7; wr_control = 2'd2;
    step();
    wr_valid = 1'b0;
    chk("resume data", 64'(rd_data), 64'd40);
    chk("resume ctl", 64'(rd_control), 64'd2);
    chk("resume level", 64'(level), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
